// File: rtl/slurm16_ifetch_pkg.sv
// slurm16 instruction-fetch responder: shared types and width helpers.
package slurm16_ifetch_pkg;

    localparam int DATA_BITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT,
        FILL
    } state_t;

    function automatic int tag_bits(input int addr_bits, input int lines);
        return addr_bits - $clog2(lines);
    endfunction

endpackage

// File: rtl/slurm16_ifetch_buffer.sv
// Direct-mapped single-word instruction buffer.
// Combinational read port, synchronous write port, clear-all of valid bits.
module slurm16_ifetch_buffer
    import slurm16_ifetch_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 11
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    input  logic                  clear_all,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_BITS-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_BITS-1:0]  wr_data
);

    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tags [LINES];
    logic [DATA_BITS-1:0] words[LINES];

    // Clear-all wins over a same-cycle write so a deferred flush drops the fill.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            valid <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = words[rd_index];

endmodule

// File: rtl/slurm16_instruction_fetch_responder.sv
// slurm16 instruction-fetch responder: buffer hits in one cycle,
// misses fetched over the shared memory read bus.
module slurm16_instruction_fetch_responder
    import slurm16_ifetch_pkg::*;
#(
    parameter int LINES     = 16,
    parameter int ADDR_BITS = 15
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic                 instruction_request,
    input  logic [ADDR_BITS-1:0] instruction_address,
    output logic                 instruction_valid,
    output logic [DATA_BITS-1:0] instruction_in,
    output logic [ADDR_BITS-1:0] instruction_address_in,
    input  logic                 instruction_flush,
    output logic                 mem_rd_req,
    output logic [ADDR_BITS-1:0] mem_rd_address,
    input  logic                 mem_rd_grant,
    input  logic                 mem_rd_valid,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic                 busy
);

    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = tag_bits(ADDR_BITS, LINES);

    state_t state;
    state_t state_next;

    logic [ADDR_BITS-1:0] miss_addr;
    logic [DATA_BITS-1:0] fill_data;
    logic                 flush_pending;

    logic                 rd_valid;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [DATA_BITS-1:0] rd_data;

    logic idle;
    logic clear_all;
    logic sample;
    logic hit;
    logic accept;

    assign idle      = (state == IDLE);
    assign clear_all = idle && (instruction_flush || flush_pending);
    assign sample    = idle && instruction_request && !clear_all;
    assign hit       = rd_valid
                    && (rd_tag == instruction_address[ADDR_BITS-1:INDEX_BITS]);
    assign accept    = (state == MISS_WAIT) && mem_rd_valid;

    slurm16_ifetch_buffer #(
        .LINES      (LINES),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_buffer (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .clear_all (clear_all),
        .rd_index  (instruction_address[INDEX_BITS-1:0]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (state == FILL),
        .wr_index  (miss_addr[INDEX_BITS-1:0]),
        .wr_tag    (miss_addr[ADDR_BITS-1:INDEX_BITS]),
        .wr_data   (fill_data)
    );

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (sample && !hit) state_next = MISS_REQ;
            MISS_REQ:  if (mem_rd_grant)   state_next = MISS_WAIT;
            MISS_WAIT: if (mem_rd_valid)   state_next = FILL;
            FILL:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            instruction_valid      <= 1'b0;
            instruction_in         <= '0;
            instruction_address_in <= '0;
            miss_addr              <= '0;
            fill_data              <= '0;
            flush_pending          <= 1'b0;
        end else begin
            instruction_valid <= 1'b0;
            if (sample && hit) begin
                instruction_valid      <= 1'b1;
                instruction_in         <= rd_data;
                instruction_address_in <= instruction_address;
            end
            if (sample && !hit) begin
                miss_addr <= instruction_address;
            end
            // Response is registered so it appears during the FILL cycle.
            if (accept) begin
                fill_data              <= mem_rd_data;
                instruction_valid      <= 1'b1;
                instruction_in         <= mem_rd_data;
                instruction_address_in <= miss_addr;
            end
            if (idle) begin
                flush_pending <= 1'b0;
            end else if (instruction_flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    assign mem_rd_req     = (state == MISS_REQ);
    assign mem_rd_address = miss_addr;
    assign busy           = !idle;

endmodule

// File: tb/tb_slurm16_instruction_fetch_responder.sv
// Self-checking bench: randomized fetch traffic against a behavioural
// buffer/memory model, plus directed branch, flush and reset scenarios.
module tb_slurm16_instruction_fetch_responder;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        instruction_request = 1'b0;
    logic [14:0] instruction_address = '0;
    logic        instruction_valid;
    logic [15:0] instruction_in;
    logic [14:0] instruction_address_in;
    logic        instruction_flush = 1'b0;
    logic        mem_rd_req;
    logic [14:0] mem_rd_address;
    logic        mem_rd_grant = 1'b0;
    logic        mem_rd_valid = 1'b0;
    logic [15:0] mem_rd_data = '0;
    logic        busy;

    int passed = 0;
    int total  = 0;

    slurm16_instruction_fetch_responder #(
        .LINES     (16),
        .ADDR_BITS (15)
    ) dut (
        .CLK                    (CLK),
        .RSTb                   (RSTb),
        .instruction_request    (instruction_request),
        .instruction_address    (instruction_address),
        .instruction_valid      (instruction_valid),
        .instruction_in         (instruction_in),
        .instruction_address_in (instruction_address_in),
        .instruction_flush      (instruction_flush),
        .mem_rd_req             (mem_rd_req),
        .mem_rd_address         (mem_rd_address),
        .mem_rd_grant           (mem_rd_grant),
        .mem_rd_valid           (mem_rd_valid),
        .mem_rd_data            (mem_rd_data),
        .busy                   (busy)
    );

    always #5 CLK = ~CLK;

    // Reference model: backing memory plus a 16-entry direct-mapped buffer.
    logic [15:0] mem_over[int];
    bit          mval[16];
    logic [10:0] mtag[16];
    logic [15:0] mdat[16];

    function automatic logic [15:0] memv(input logic [14:0] a);
        if (mem_over.exists(int'(a))) return mem_over[int'(a)];
        return (16'(a) * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic bit m_hit(input logic [14:0] a);
        return mval[a[3:0]] && (mtag[a[3:0]] == a[14:4]);
    endfunction

    function automatic logic [15:0] m_data(input logic [14:0] a);
        return m_hit(a) ? mdat[a[3:0]] : memv(a);
    endfunction

    function automatic void m_fill(input logic [14:0] a, input logic [15:0] d);
        mval[a[3:0]] = 1'b1;
        mtag[a[3:0]] = a[14:4];
        mdat[a[3:0]] = d;
    endfunction

    function automatic void m_flush();
        foreach (mval[i]) mval[i] = 1'b0;
    endfunction

    typedef struct {
        bit          ok;
        bit          used;
        bit          hold_ok;
        bit          drop_ok;
        bit          after_ok;
        bit          single_ok;
        logic [15:0] data;
        logic [14:0] addr;
        int          lat;
    } res_t;

    // Drives one CPU fetch and plays the memory arbiter; called at a negedge.
    task automatic fetch(input logic [14:0] a, input int gw, input int dw,
                         output res_t r);
        int gc = 0;
        int dc = 0;
        int vk = -10;
        bit granted = 0;
        bit sent = 0;
        logic [14:0] gaddr = '0;
        r.ok = 0; r.used = 0; r.hold_ok = 1; r.drop_ok = 1;
        r.after_ok = 0; r.single_ok = 0;
        r.data = '0; r.addr = '0; r.lat = 0;
        instruction_request = 1'b1;
        instruction_address = a;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (mem_rd_valid) mem_rd_valid = 1'b0;
            if (mem_rd_grant) begin
                mem_rd_grant = 1'b0;
                granted = 1;
                if (mem_rd_req !== 1'b0) r.drop_ok = 0;
            end
            if (instruction_valid === 1'b1) begin
                r.ok = 1;
                r.data = instruction_in;
                r.addr = instruction_address_in;
                r.lat = k;
                r.after_ok = (k == vk + 1);
                break;
            end
            if (!granted && mem_rd_req === 1'b1) begin
                r.used = 1;
                if (mem_rd_address !== a) r.hold_ok = 0;
                if (gc == gw) begin
                    mem_rd_grant = 1'b1;
                    gaddr = mem_rd_address;
                end else begin
                    gc++;
                end
            end else if (granted && !sent) begin
                if (dc == dw) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data = memv(gaddr);
                    sent = 1;
                    vk = k;
                end else begin
                    dc++;
                end
            end
        end
        instruction_request = 1'b0;
        mem_rd_grant = 1'b0;
        mem_rd_valid = 1'b0;
        @(negedge CLK);
        r.single_ok = (instruction_valid === 1'b0);
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (instruction_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instruction_valid); else passed++;
        total++; if (instruction_in !== 16'h0) $display("FAIL reset_data got %h want 0", instruction_in); else passed++;
        total++; if (instruction_address_in !== 15'h0) $display("FAIL reset_addr got %h want 0", instruction_address_in); else passed++;
        total++; if (mem_rd_req !== 1'b0) $display("FAIL reset_req got %b want 0", mem_rd_req); else passed++;
        total++; if (mem_rd_address !== 15'h0) $display("FAIL reset_rdaddr got %h want 0", mem_rd_address); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        RSTb = 1'b1;
        m_flush();
        @(negedge CLK);
    endtask

    task automatic test_cold_miss();
        res_t r;
        mem_over[5] = 16'h3013;
        fetch(15'h0005, 2, 3, r);
        total++; if (!r.ok) $display("FAIL cold_timeout got no response want one"); else passed++;
        total++; if (r.used !== 1'b1) $display("FAIL cold_used got %b want 1", r.used); else passed++;
        total++; if (r.data !== 16'h3013) $display("FAIL cold_data got %h want 3013", r.data); else passed++;
        total++; if (r.addr !== 15'h0005) $display("FAIL cold_addr got %h want 0005", r.addr); else passed++;
        total++; if (!r.hold_ok) $display("FAIL cold_hold got changed want held 0005"); else passed++;
        total++; if (!r.drop_ok) $display("FAIL cold_drop got req high want 0 after grant"); else passed++;
        total++; if (!r.after_ok) $display("FAIL cold_latency got lat %0d want 1 after rd_valid", r.lat); else passed++;
        total++; if (!r.single_ok) $display("FAIL cold_pulse got 2nd valid want single"); else passed++;
        m_fill(15'h0005, 16'h3013);
    endtask

    task automatic test_hit_stream();
        res_t r;
        logic [15:0] exp[3];
        exp[0] = 16'h3013; exp[1] = 16'h3027; exp[2] = 16'h2112;
        for (int i = 0; i < 3; i++) begin
            mem_over[i] = exp[i];
            fetch(15'(i), i, 2 - i, r);
            total++; if (!r.ok || r.data !== exp[i]) $display("FAIL hs_fill%0d got %h want %h", i, r.data, exp[i]); else passed++;
            m_fill(15'(i), r.data);
        end
        instruction_request = 1'b1;
        instruction_address = 15'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (instruction_valid !== 1'b1 || instruction_in !== exp[i]
                || instruction_address_in !== 15'(i) || mem_rd_req !== 1'b0)
                $display("FAIL hs_hit%0d got v%b %h @%h req%b want v1 %h @%h req0",
                         i, instruction_valid, instruction_in,
                         instruction_address_in, mem_rd_req, exp[i], 15'(i));
            else passed++;
            instruction_address = 15'(i + 1);
        end
        instruction_request = 1'b0;
        @(negedge CLK);
        total++; if (instruction_valid !== 1'b0) $display("FAIL hs_end got %b want 0", instruction_valid); else passed++;
    endtask

    task automatic test_conflict();
        res_t r;
        logic [14:0] seq[3];
        bit eh;
        logic [15:0] ed;
        seq[0] = 15'h0003; seq[1] = 15'h0013; seq[2] = 15'h0003;
        for (int i = 0; i < 3; i++) begin
            eh = m_hit(seq[i]);
            ed = m_data(seq[i]);
            fetch(seq[i], 1, 1, r);
            total++;
            if (!r.ok || r.used !== 1'b1 || eh || r.data !== ed || r.addr !== seq[i])
                $display("FAIL conflict%0d got used%b %h @%h want miss %h @%h",
                         i, r.used, r.data, r.addr, ed, seq[i]);
            else passed++;
            m_fill(seq[i], ed);
        end
    endtask

    task automatic test_branch();
        res_t r;
        mem_over[16'h10] = 16'hBEEF;
        mem_over[16'h20] = 16'h1234;
        instruction_request = 1'b1;
        instruction_address = 15'h0010;
        @(negedge CLK);
        total++; if (mem_rd_req !== 1'b1 || mem_rd_address !== 15'h0010) $display("FAIL br_req got %b @%h want 1 @0010", mem_rd_req, mem_rd_address); else passed++;
        mem_rd_grant = 1'b1;
        @(negedge CLK);
        mem_rd_grant = 1'b0;
        instruction_address = 15'h0020;
        total++; if (busy !== 1'b1) $display("FAIL br_busy got %b want 1", busy); else passed++;
        @(negedge CLK);
        mem_rd_valid = 1'b1;
        mem_rd_data = memv(15'h0010);
        @(negedge CLK);
        mem_rd_valid = 1'b0;
        total++;
        if (instruction_valid !== 1'b1 || instruction_in !== 16'hBEEF || instruction_address_in !== 15'h0010)
            $display("FAIL br_old got v%b %h @%h want v1 beef @0010", instruction_valid, instruction_in, instruction_address_in);
        else passed++;
        m_fill(15'h0010, 16'hBEEF);
        fetch(15'h0020, 1, 0, r);
        total++;
        if (!r.ok || r.used !== 1'b1 || r.data !== 16'h1234 || r.addr !== 15'h0020)
            $display("FAIL br_new got used%b %h @%h want miss 1234 @0020", r.used, r.data, r.addr);
        else passed++;
        m_fill(15'h0020, 16'h1234);
    endtask

    task automatic test_flush();
        res_t r;
        instruction_flush = 1'b1;
        instruction_request = 1'b1;
        instruction_address = 15'h0001;
        @(negedge CLK);
        instruction_flush = 1'b0;
        instruction_request = 1'b0;
        total++; if (instruction_valid !== 1'b0) $display("FAIL fl_idle got %b want 0", instruction_valid); else passed++;
        m_flush();
        fetch(15'h0001, 0, 1, r);
        total++; if (!r.ok || r.used !== 1'b1 || r.data !== m_data(15'h0001)) $display("FAIL fl_refetch got used%b %h want miss %h", r.used, r.data, m_data(15'h0001)); else passed++;
        m_fill(15'h0001, r.data);
        instruction_request = 1'b1;
        instruction_address = 15'h0002;
        @(negedge CLK);
        mem_rd_grant = 1'b1;
        @(negedge CLK);
        mem_rd_grant = 1'b0;
        instruction_flush = 1'b1;
        @(negedge CLK);
        instruction_flush = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data = memv(15'h0002);
        @(negedge CLK);
        mem_rd_valid = 1'b0;
        instruction_request = 1'b0;
        total++;
        if (instruction_valid !== 1'b1 || instruction_in !== memv(15'h0002) || instruction_address_in !== 15'h0002)
            $display("FAIL fl_miss got v%b %h @%h want v1 %h @0002", instruction_valid, instruction_in, instruction_address_in, memv(15'h0002));
        else passed++;
        m_flush();
        fetch(15'h0002, 0, 0, r);
        total++; if (!r.ok || r.used !== 1'b1 || r.data !== memv(15'h0002)) $display("FAIL fl_after got used%b %h want miss %h", r.used, r.data, memv(15'h0002)); else passed++;
        m_fill(15'h0002, r.data);
        fetch(15'h0001, 0, 0, r);
        total++; if (!r.ok || r.used !== 1'b1) $display("FAIL fl_cleared got used%b want miss", r.used); else passed++;
        m_fill(15'h0001, r.data);
    endtask

    task automatic test_reset_mid_miss();
        res_t r;
        bit stray = 0;
        instruction_request = 1'b1;
        instruction_address = 15'h0777;
        @(negedge CLK);
        total++; if (mem_rd_req !== 1'b1) $display("FAIL rm_req got %b want 1", mem_rd_req); else passed++;
        #2 RSTb = 1'b0;
        #1;
        total++; if (mem_rd_req !== 1'b0 || busy !== 1'b0) $display("FAIL rm_async got req%b busy%b want 0 0", mem_rd_req, busy); else passed++;
        instruction_request = 1'b0;
        @(negedge CLK);
        RSTb = 1'b1;
        m_flush();
        @(negedge CLK);
        mem_rd_valid = 1'b1;
        mem_rd_data = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            mem_rd_valid = 1'b0;
            if (instruction_valid !== 1'b0) stray = 1;
        end
        total++; if (stray) $display("FAIL rm_stray got valid want none"); else passed++;
        fetch(15'h0005, 0, 0, r);
        total++; if (!r.ok || r.used !== 1'b1 || r.data !== 16'h3013) $display("FAIL rm_cleared got used%b %h want miss 3013", r.used, r.data); else passed++;
        m_fill(15'h0005, r.data);
    endtask

    task automatic test_random();
        res_t r;
        logic [14:0] a;
        bit eh;
        logic [15:0] ed;
        int gw;
        int dw;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    instruction_flush = 1'b1;
                    @(negedge CLK);
                    instruction_flush = 1'b0;
                    m_flush();
                end
                1: begin
                    mem_over[$urandom_range(0, 63)] = 16'($urandom);
                end
                default: begin
                    if ($urandom_range(0, 7) == 0) a = 15'($urandom);
                    else a = 15'($urandom_range(0, 63));
                    gw = $urandom_range(0, 3);
                    dw = $urandom_range(0, 3);
                    eh = m_hit(a);
                    ed = m_data(a);
                    fetch(a, gw, dw, r);
                    total++;
                    if (!r.ok || r.used !== !eh || r.data !== ed || r.addr !== a)
                        $display("FAIL rnd%0d got ok%b used%b %h @%h want used%b %h @%h",
                                 n, r.ok, r.used, r.data, r.addr, !eh, ed, a);
                    else passed++;
                    total++;
                    if (!r.single_ok || (eh && r.lat != 1)
                        || (!eh && !(r.after_ok && r.hold_ok && r.drop_ok)))
                        $display("FAIL rnd%0d_timing got lat%0d s%b a%b h%b d%b want ok",
                                 n, r.lat, r.single_ok, r.after_ok, r.hold_ok, r.drop_ok);
                    else passed++;
                    m_fill(a, ed);
                end
            endcase
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_conflict();
        test_branch();
        test_flush();
        test_reset_mid_miss();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
